// File: rtl/spike_packet_transmitter_pkg.sv
// spike_packet_transmitter_pkg: shared NoC packet geometry, sizing and FSM state encoding
package spike_packet_transmitter_pkg;
  localparam int NUM_NEURONS  = 10;
  localparam int ADDR_WIDTH   = 12;
  localparam int TS_WIDTH     = 8;
  localparam int IDX_WIDTH    = $clog2(NUM_NEURONS);
  localparam int PKT_WIDTH    = TS_WIDTH + ADDR_WIDTH;
  localparam int PKT_ADDR_LSB = 0;
  localparam int PKT_ADDR_MSB = ADDR_WIDTH - 1;
  localparam int PKT_TS_LSB   = ADDR_WIDTH;
  localparam int PKT_TS_MSB   = PKT_WIDTH - 1;
  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;
endpackage

// File: rtl/spike_priority_encoder.sv
// spike_priority_encoder: index of the lowest set bit of a mask, plus an any-set flag
//   mask_i  in   N-bit request mask
//   idx_o   out  lowest set index (0 when mask is empty)
//   any_o   out  mask has at least one bit set
module spike_priority_encoder #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) idx_o = mask_i[i] ? W'(i) : idx_o;
  end
  assign any_o = |mask_i;
endmodule

// File: rtl/spike_packet_transmitter.sv
// spike_packet_transmitter: serialises one {timestep, address} NoC packet per spiking neuron
//   clk_i / rst_i                        clock, asynchronous active-high reset
//   clear_i                              timestep boundary pulse: capture spikes, bump counter
//   init_en_i, neuron_addresses_init_i   load address table (neuron 0 in MSBs), IDLE only
//   spike_vector_i                       bit i = neuron i fired
//   packet_out_o, packet_valid_o         packet and its valid, held until packet_ready_i
//   timestep_done_o                      1-cycle pulse once a timestep's packets are all sent
//   overrun_error_o                      sticky: a clear arrived with packets still pending
module spike_packet_transmitter
  import spike_packet_transmitter_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              init_en_i,
  input  logic [NUM_NEURONS*ADDR_WIDTH-1:0] neuron_addresses_init_i,
  input  logic [NUM_NEURONS-1:0]            spike_vector_i,
  output logic [PKT_WIDTH-1:0]              packet_out_o,
  output logic                              packet_valid_o,
  input  logic                              packet_ready_i,
  output logic                              timestep_done_o,
  output logic                              overrun_error_o
);
  state_e                 state_q, state_d;
  logic [NUM_NEURONS-1:0] pending_q, pending_d, pend_left;
  logic [TS_WIDTH-1:0]    ts_cnt_q, ts_lat_q, ts_lat_d;
  logic [ADDR_WIDTH-1:0]  addr_q [NUM_NEURONS];
  logic                   done_q, done_d, overrun_q, overrun_d;
  logic [IDX_WIDTH-1:0]   idx;
  logic                   any, hs, sending;
  spike_priority_encoder #(.N(NUM_NEURONS), .W(IDX_WIDTH)) u_enc (
    .mask_i(pending_q),
    .idx_o (idx),
    .any_o (any)
  );
  assign sending = (state_q == ST_SEND) && any;
  assign hs = sending && packet_ready_i;
  assign pend_left = hs ? pending_q & ~(NUM_NEURONS'(1) << idx) : pending_q;
  assign packet_valid_o = sending;
  assign packet_out_o[PKT_TS_MSB:PKT_TS_LSB] = sending ? ts_lat_q : '0;
  assign packet_out_o[PKT_ADDR_MSB:PKT_ADDR_LSB] = sending ? addr_q[idx] : '0;
  assign timestep_done_o = done_q;
  assign overrun_error_o = overrun_q;
  // A clear closes the current timestep: leftover packets are an overrun, a clean finish
  // on the same edge still earns its done pulse, and an empty new capture finishes at once.
  always_comb begin
    state_d   = state_q;
    pending_d = pend_left;
    ts_lat_d  = ts_lat_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    if (clear_i) begin
      overrun_d = overrun_q | ((state_q == ST_SEND) && |pend_left);
      done_d    = ((state_q == ST_SEND) && !(|pend_left)) || !(|spike_vector_i);
      pending_d = spike_vector_i;
      ts_lat_d  = ts_cnt_q;
      state_d   = |spike_vector_i ? ST_SEND : ST_IDLE;
    end else if (state_q == ST_SEND && !(|pend_left)) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ts_cnt_q  <= '0;
      ts_lat_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) addr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ts_lat_q  <= ts_lat_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      if (clear_i) ts_cnt_q <= ts_cnt_q + 1'b1;
      if (init_en_i && state_q == ST_IDLE)
        for (int i = 0; i < NUM_NEURONS; i++)
          addr_q[i] <= neuron_addresses_init_i[(NUM_NEURONS-1-i)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end
endmodule

// File: tb/tb_spike_packet_transmitter.sv
// tb_spike_packet_transmitter: randomized scenarios checked against a packet-list reference model
module tb_spike_packet_transmitter;
  logic         clk = 1'b0;
  logic         rst, clear_i, init_en_i, packet_ready_i;
  logic [119:0] addr_vec;
  logic [9:0]   spike_vector_i;
  logic [19:0]  packet_out_o;
  logic         packet_valid_o, timestep_done_o, overrun_error_o;
  spike_packet_transmitter dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .clear_i                (clear_i),
    .init_en_i              (init_en_i),
    .neuron_addresses_init_i(addr_vec),
    .spike_vector_i         (spike_vector_i),
    .packet_out_o           (packet_out_o),
    .packet_valid_o         (packet_valid_o),
    .packet_ready_i         (packet_ready_i),
    .timestep_done_o        (timestep_done_o),
    .overrun_error_o        (overrun_error_o)
  );
  always #5 clk = ~clk;
  int          n_tests = 0, n_fail = 0;
  int          m_cnt;
  logic [11:0] m_addr [10];
  logic [19:0] exp_q[$], got_q[$];
  int          got_cyc[$];
  int          cyc = 0, done_cnt = 0, unstable = 0;
  logic        o_valid, o_done, prev_stall = 1'b0, timed_out;
  logic [19:0] o_pkt, prev_pkt;
  task automatic pack_addrs();
    for (int i = 0; i < 10; i++) addr_vec[(9-i)*12 +: 12] = m_addr[i];
  endtask
  task automatic add_exp(input logic [9:0] sp);
    for (int i = 0; i < 10; i++) if (sp[i]) exp_q.push_back({m_cnt[7:0], m_addr[i]});
    m_cnt = (m_cnt + 1) % 256;
  endtask
  task automatic step(input logic clr, input logic [9:0] sp, input logic rdy);
    clear_i = clr; spike_vector_i = sp; packet_ready_i = rdy;
    #1;
    o_valid = packet_valid_o; o_pkt = packet_out_o; o_done = timestep_done_o;
    if (prev_stall && (!o_valid || o_pkt !== prev_pkt)) unstable++;
    prev_stall = o_valid && !rdy && !clr;
    prev_pkt = o_pkt;
    if (o_valid && rdy) begin got_q.push_back(o_pkt); got_cyc.push_back(cyc); end
    if (o_done) done_cnt++;
    cyc++;
    @(negedge clk);
    clear_i = 1'b0;
  endtask
  task automatic drain(input bit rnd, input int budget);
    int start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) step(0, '0, rnd ? 1'($urandom) : 1'b1);
    timed_out = (done_cnt == start);
  endtask
  task automatic cmp_lists(input string nm);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d packets, expected %0d", nm, got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s pkt%0d: got %h expected %h", nm, i, got_q[i], exp_q[i]);
        end
      end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask
  task automatic test_reset();
    rst = 1'b1; clear_i = 0; init_en_i = 0; packet_ready_i = 0; spike_vector_i = '0; addr_vec = '0;
    m_cnt = 0;
    for (int i = 0; i < 10; i++) m_addr[i] = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({packet_valid_o, timestep_done_o, overrun_error_o, packet_out_o} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%b o=%b p=%h expected all 0", packet_valid_o,
               timestep_done_o, overrun_error_o, packet_out_o);
    end
    rst = 1'b0;
  endtask
  task automatic test_basic();
    int d0;
    for (int i = 0; i < 10; i++) m_addr[i] = 12'(i);
    pack_addrs(); init_en_i = 1; step(0, '0, 1); init_en_i = 0;
    d0 = done_cnt;
    add_exp(10'b0000000101);
    step(1, 10'b0000000101, 1);
    drain(0, 30);
    n_tests++;
    if (timed_out || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0);
    end
    n_tests++;
    if (got_cyc.size() != 2 || got_cyc[1] - got_cyc[0] != 1) begin
      n_fail++; $display("FAIL basic_consecutive: got %0d handshakes not back-to-back, expected 2 consecutive", got_cyc.size());
    end
    cmp_lists("basic");
  endtask
  task automatic test_empty();
    add_exp('0);
    step(1, '0, 1);
    step(0, '0, 1);
    n_tests++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_done: got done=%b valid=%b expected done=1 valid=0", o_done, o_valid);
    end
    step(0, '0, 1);
    n_tests++;
    if (o_done !== 1'b0) begin
      n_fail++; $display("FAIL empty_pulse_width: got done=%b expected 0", o_done);
    end
  endtask
  task automatic test_ready_toggle();
    for (int i = 0; i < 10; i++) m_addr[i] = 12'($urandom);
    pack_addrs(); init_en_i = 1; step(0, '0, 1); init_en_i = 0;
    for (int r = 0; r < 5; r++) begin
      logic [9:0] sp;
      int d0 = done_cnt;
      sp = (r == 0) ? 10'h3FF : 10'($urandom_range(1, 1023));
      unstable = 0;
      add_exp(sp);
      step(1, sp, 1'($urandom));
      drain(1, 200);
      n_tests++;
      if (timed_out || done_cnt - d0 != 1) begin
        n_fail++; $display("FAIL toggle_done r%0d: got %0d pulses expected 1", r, done_cnt - d0);
      end
      n_tests++;
      if (unstable != 0) begin
        n_fail++; $display("FAIL toggle_stable r%0d: got %0d unstable stalls expected 0", r, unstable);
      end
      cmp_lists("toggle");
    end
  endtask
  task automatic test_overrun();
    logic [7:0] ts1;
    int d0 = done_cnt;
    n_tests++;
    if (overrun_error_o !== 1'b0) begin
      n_fail++; $display("FAIL overrun_pre: got %b expected 0", overrun_error_o);
    end
    m_cnt = (m_cnt + 1) % 256;
    step(1, 10'h3FF, 0);
    repeat (3) step(0, '0, 0);
    ts1 = m_cnt[7:0];
    add_exp(10'b1);
    step(1, 10'b1, 0);
    step(0, '0, 0);
    n_tests++;
    if (overrun_error_o !== 1'b1) begin
      n_fail++; $display("FAIL overrun_flag: got %b expected 1", overrun_error_o);
    end
    n_tests++;
    if (o_valid !== 1'b1 || o_pkt !== {ts1, m_addr[0]}) begin
      n_fail++; $display("FAIL overrun_next: got v=%b p=%h expected v=1 p=%h", o_valid, o_pkt, {ts1, m_addr[0]});
    end
    drain(0, 20);
    step(0, '0, 1);
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL overrun_done: got %0d pulses expected 1", done_cnt - d0);
    end
    cmp_lists("overrun");
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      add_exp(10'b1);
      step(1, 10'b1, 1);
      drain(0, 6);
    end
    cmp_lists("wrap");
  endtask
  task automatic test_reset_mid_send();
    for (int i = 0; i < 10; i++) m_addr[i] = 12'($urandom);
    pack_addrs(); init_en_i = 1; step(0, '0, 1); init_en_i = 0;
    add_exp(10'h3FF);
    step(1, 10'h3FF, 0);
    for (int i = 0; i < 10; i++) addr_vec[i*12 +: 12] = ~m_addr[9-i];
    init_en_i = 1;
    repeat (3) step(0, '0, 1);
    init_en_i = 0;
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    cmp_lists("init_in_send");
    rst = 1'b1;
    #1;
    n_tests++;
    if ({packet_valid_o, timestep_done_o, overrun_error_o, packet_out_o} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_mid_send: got v=%b d=%b o=%b p=%h expected all 0", packet_valid_o,
               timestep_done_o, overrun_error_o, packet_out_o);
    end
    @(negedge clk);
    rst = 1'b0; prev_stall = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 10; i++) m_addr[i] = '0;
    add_exp(10'b10);
    step(1, 10'b10, 1);
    drain(0, 10);
    cmp_lists("after_reset");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_ready_toggle();
    test_overrun();
    test_wrap();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
